// File: rtl/bcd_counter_pkg.sv
// Shared definitions for the 4-digit BCD up/down counter.
//   NDIGITS : number of chained BCD digits
//   BCD_MAX : largest legal BCD digit value
//   state_t : start/stop FSM encoding (STOPPED = 0, RUNNING = 1)
package bcd_counter_pkg;

  localparam int unsigned NDIGITS = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (digit -> 0)
//   clr       in   synchronous clear (digit -> 0)
//   ld        in   load request; ld_val above 9 loads as 0
//   ld_val    in   [3:0] preset value
//   step      in   global count-step enable
//   up        in   1 = increment, 0 = decrement
//   cin_bin   in   carry (up) / borrow (down) from the less significant digit
//   q         out  [3:0] registered digit value
//   cout_bout out  carry/borrow into the next digit (combinational)
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       step,
  input  logic       up,
  input  logic       cin_bin,
  output logic [3:0] q,
  output logic       cout_bout
);

  logic [3:0] nxt;

  // Out-of-range values cannot arise (reset and load sanitise), but they
  // are mapped onto the wrap value so the digit always re-enters 0..9.
  always_comb begin
    nxt = q;
    if (up) begin
      nxt = (q >= BCD_MAX) ? '0 : q + 4'd1;
    end else begin
      nxt = ((q == '0) || (q > BCD_MAX)) ? BCD_MAX : q - 4'd1;
    end
  end

  // This digit wraps exactly when it is asked to change and sits at the edge.
  assign cout_bout = cin_bin & (up ? (q == BCD_MAX) : (q == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= (ld_val > BCD_MAX) ? '0 : ld_val;
    end else if (step && cin_bin) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bcd_counter4.sv
// 4-digit BCD up/down counter with start/stop FSM, prescaler and preset.
// Parameter:
//   DIV      clk cycles per count step (>= 2)
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   ss       in   start/stop toggle pulse
//   clr      in   clear digits and prescaler (FSM state kept)
//   up       in   count direction, sampled at each step
//   load     in   load pulse, honoured only while stopped
//   load_val in   [15:0] BCD preset, digit 3 in [15:12]
//   d0..d3   out  [3:0] registered BCD digits, d0 least significant
//   running  out  high while RUNNING
//   tick     out  one-cycle pulse when new digit values first appear
//   ovf      out  one-cycle pulse with tick on a 9999<->0000 wrap
module bcd_counter4
  import bcd_counter_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss,
  input  logic        clr,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  d0,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3,
  output logic        running,
  output logic        tick,
  output logic        ovf
);

  localparam int            PW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  state_t              state;
  logic [PW-1:0]       presc;
  logic                step;
  logic                ld;
  logic [NDIGITS:0]    carry;
  logic [3:0]          q [NDIGITS];

  // clr outranks the step, so a clear on the terminal prescaler count
  // produces neither a digit change nor a tick/ovf.
  assign step = (state == RUNNING) && (presc == PMAX) && !clr;
  assign ld   = load && (state == STOPPED);

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .ld        (ld),
      .ld_val    (load_val[4*i +: 4]),
      .step      (step),
      .up        (up),
      .cin_bin   (carry[i]),
      .q         (q[i]),
      .cout_bout (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STOPPED;
      presc <= '0;
      tick  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (ss) begin
        state <= (state == STOPPED) ? RUNNING : STOPPED;
      end
      // Prescaler holds while stopped so a resume keeps the partial period.
      if (clr) begin
        presc <= '0;
      end else if (state == RUNNING) begin
        presc <= (presc == PMAX) ? '0 : presc + PW'(1);
      end
      tick <= step;
      ovf  <= step & carry[NDIGITS];
    end
  end

  assign running = (state == RUNNING);
  assign d0      = q[0];
  assign d1      = q[1];
  assign d2      = q[2];
  assign d3      = q[3];

endmodule
